// File: rtl/flat_sched_pkg.sv
// Shared types and lane-mapping helpers for the flattening input scheduler.
package flat_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} glob_state_t;
  typedef enum logic [1:0] {L_IDLE, L_SCAN, L_HOLD, L_FIN} lane_state_t;

  function automatic int lane_of(input int img, input int num_inputs);
    return img % num_inputs;
  endfunction

  // Low lanes get the ceiling share, the rest the floor; lanes past the image count get none.
  function automatic int images_on_lane(input int lane, input int num_images, input int num_inputs);
    if (lane >= num_images) return 0;
    return (num_images - lane + num_inputs - 1) / num_inputs;
  endfunction

endpackage

// File: rtl/flat_lane_arbiter.sv
// One shared lane: round-robin grant among its images, pixel capture, fixed-length hold.
//   state  | meaning
//   L_IDLE | no frame active
//   L_SCAN | looking for a requesting image still short of ImageSize pixels
//   L_HOLD | presenting the captured pixel for CyclesPerPixel cycles
//   L_FIN  | every image on this lane complete; waiting for global IDLE
module flat_lane_arbiter
  import flat_sched_pkg::*;
#(
  parameter int BitSize        = 2,
  parameter int ImageSize      = 9,
  parameter int CyclesPerPixel = 4,
  parameter int Slots          = 2,
  parameter int NumImg         = 2
) (
  input  logic                           clk,
  input  logic                           res_n,
  input  logic                           run_entry,
  input  logic                           glob_idle,
  input  logic [Slots-1:0]               valid,
  input  logic [Slots-1:0][BitSize-1:0]  data,
  output logic [Slots-1:0]               ready,
  output logic [Slots-1:0]               hold_valid,
  output logic [BitSize-1:0]             hold_data,
  output logic                           fin
);

  localparam int CW = $clog2(ImageSize + 1);
  localparam int HW = $clog2(CyclesPerPixel + 1);
  localparam int PW = (Slots > 1) ? $clog2(Slots) : 1;

  lane_state_t              state, state_nxt;
  logic [PW-1:0]            ptr, sel, gidx, idx;
  logic [PW:0]              sum;
  logic [Slots-1:0][CW-1:0] cnt;
  logic [HW-1:0]            hold_cnt;
  logic [BitSize-1:0]       lane_reg;
  logic [Slots-1:0]         img_done, cand;
  logic                     found, all_done, grant;

  // Slots beyond NumImg are padding and count as already complete.
  always_comb begin
    img_done = '0;
    cand     = '0;
    for (int k = 0; k < Slots; k++) begin
      img_done[k] = (k >= NumImg) || (cnt[k] == CW'(ImageSize));
      cand[k]     = valid[k] && !img_done[k];
    end
  end

  assign all_done = &img_done;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    sum   = '0;
    idx   = '0;
    for (int j = 0; j < Slots; j++) begin
      sum = {1'b0, ptr} + (PW+1)'(j);
      if (sum >= (PW+1)'(Slots)) sum = sum - (PW+1)'(Slots);
      idx = sum[PW-1:0];
      if (!found && cand[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  assign grant = (state == L_SCAN) && !all_done && found;

  always_comb begin
    state_nxt = state;
    unique case (state)
      L_IDLE: if (run_entry) state_nxt = L_SCAN;
      L_SCAN: begin
        if (all_done)   state_nxt = L_FIN;
        else if (found) state_nxt = L_HOLD;
      end
      L_HOLD: if (hold_cnt == '0) state_nxt = L_SCAN;
      L_FIN: begin
        if (run_entry)      state_nxt = L_SCAN;
        else if (glob_idle) state_nxt = L_IDLE;
      end
      default: state_nxt = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= L_IDLE;
      ptr      <= '0;
      sel      <= '0;
      cnt      <= '0;
      hold_cnt <= '0;
      lane_reg <= '0;
    end else begin
      state <= state_nxt;
      if (run_entry) begin
        ptr <= '0;
        cnt <= '0;
      end else if (grant) begin
        cnt[gidx] <= cnt[gidx] + 1'b1;
        ptr       <= (gidx == PW'(Slots - 1)) ? '0 : gidx + 1'b1;
        sel       <= gidx;
        lane_reg  <= data[gidx];
        hold_cnt  <= HW'(CyclesPerPixel - 1);
      end else if (state == L_HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    ready      = '0;
    hold_valid = '0;
    if (grant)            ready[gidx]     = 1'b1;
    if (state == L_HOLD)  hold_valid[sel] = 1'b1;
  end

  assign hold_data = (state == L_HOLD) ? lane_reg : '0;
  assign fin       = (state == L_FIN);

endmodule

// File: rtl/flatten_input_scheduler.sv
// Time-multiplexes per-image pixel sources onto the shared flattening lanes.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | lanes arbitrating; frame in progress
//   DONE  | one-cycle completion pulse
module flatten_input_scheduler
  import flat_sched_pkg::*;
#(
  parameter int BitSize        = 2,
  parameter int ImageSize      = 9,
  parameter int NumOfImages    = 4,
  parameter int NumOfInputs    = 2,
  parameter int CyclesPerPixel = 4
) (
  input  logic                                 clk,
  input  logic                                 res_n,
  input  logic                                 start,
  input  logic [NumOfImages-1:0]               src_valid,
  input  logic [NumOfImages-1:0][BitSize-1:0]  src_data,
  output logic [NumOfImages-1:0]               src_ready,
  output logic [NumOfImages-1:0]               fl_valid,
  output logic [NumOfInputs-1:0][BitSize-1:0]  fl_data,
  output logic                                 busy,
  output logic                                 done
);

  localparam int MaxImg = images_on_lane(0, NumOfImages, NumOfInputs);
  localparam int Slots  = (MaxImg > 0) ? MaxImg : 1;

  glob_state_t state, state_nxt;
  logic        run_entry, glob_idle;
  logic [NumOfInputs-1:0]                          lane_fin;
  logic [NumOfInputs-1:0][Slots-1:0]               lane_valid, lane_ready, lane_hold;
  logic [NumOfInputs-1:0][Slots-1:0][BitSize-1:0]  lane_data;

  assign glob_idle = (state == IDLE);
  assign run_entry = glob_idle && start;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (&lane_fin) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Local slot k of lane l carries image l + k*NumOfInputs.
  for (genvar l = 0; l < NumOfInputs; l++) begin : g_lane
    for (genvar k = 0; k < Slots; k++) begin : g_slot
      if (l + k * NumOfInputs < NumOfImages) begin : g_map
        assign lane_valid[l][k] = src_valid[l + k * NumOfInputs];
        assign lane_data[l][k]  = src_data[l + k * NumOfInputs];
      end else begin : g_pad
        assign lane_valid[l][k] = 1'b0;
        assign lane_data[l][k]  = '0;
      end
    end

    flat_lane_arbiter #(
      .BitSize        (BitSize),
      .ImageSize      (ImageSize),
      .CyclesPerPixel (CyclesPerPixel),
      .Slots          (Slots),
      .NumImg         (images_on_lane(l, NumOfImages, NumOfInputs))
    ) u_lane (
      .clk        (clk),
      .res_n      (res_n),
      .run_entry  (run_entry),
      .glob_idle  (glob_idle),
      .valid      (lane_valid[l]),
      .data       (lane_data[l]),
      .ready      (lane_ready[l]),
      .hold_valid (lane_hold[l]),
      .hold_data  (fl_data[NumOfInputs-1-l]),
      .fin        (lane_fin[l])
    );
  end

  for (genvar i = 0; i < NumOfImages; i++) begin : g_img
    assign src_ready[i]               = lane_ready[lane_of(i, NumOfInputs)][i / NumOfInputs];
    assign fl_valid[NumOfImages-1-i]  = lane_hold[lane_of(i, NumOfInputs)][i / NumOfInputs];
  end

endmodule

// File: tb/tb_flatten_input_scheduler.sv
// Scoreboard bench: a cycle model predicts grants/holds; captured pixels are queued and matched on lane output.
module tb_flatten_input_scheduler;

  localparam int BW    = 2;
  localparam int ISZ   = 9;
  localparam int NIMG  = 4;
  localparam int NIN   = 2;
  localparam int CPP   = 4;
  localparam int NIMG2 = 3;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic [NIMG-1:0]            src_valid = '0;
  logic [NIMG-1:0][BW-1:0]    src_data = '0;
  logic [NIMG-1:0]            src_ready;
  logic [NIMG-1:0]            fl_valid;
  logic [NIN-1:0][BW-1:0]     fl_data;
  logic                       busy, done;

  logic [NIMG2-1:0]           src_valid2 = '1;
  logic [NIMG2-1:0][BW-1:0]   src_data2 = '0;
  logic [NIMG2-1:0]           src_ready2;
  logic [NIMG2-1:0]           fl_valid2;
  logic [NIN-1:0][BW-1:0]     fl_data2;
  logic                       busy2, done2;

  always #5 clk = ~clk;

  flatten_input_scheduler #(.BitSize(BW), .ImageSize(ISZ), .NumOfImages(NIMG),
                            .NumOfInputs(NIN), .CyclesPerPixel(CPP)) dut (
    .clk(clk), .res_n(res_n), .start(start), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .fl_valid(fl_valid), .fl_data(fl_data), .busy(busy), .done(done));

  flatten_input_scheduler #(.BitSize(BW), .ImageSize(ISZ), .NumOfImages(NIMG2),
                            .NumOfInputs(NIN), .CyclesPerPixel(CPP)) dut3 (
    .clk(clk), .res_n(res_n), .start(start2), .src_valid(src_valid2), .src_data(src_data2),
    .src_ready(src_ready2), .fl_valid(fl_valid2), .fl_data(fl_data2), .busy(busy2), .done(done2));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct { int lane; int img; int data; } sb_t;
  sb_t sbq[$];

  // Reference model state: global 0 idle / 1 run / 2 done; lane 0 idle / 1 scan / 2 hold / 3 fin.
  int g_st;
  int l_st[NIN], l_ptr[NIN], l_hold[NIN], l_img[NIN], l_dat[NIN];
  int m_cnt[NIMG];
  int gcount[NIMG];
  int done_cnt;
  logic [NIN-1:0] prev_lv;

  function automatic int nl_of(input int l);
    return (NIMG - l + NIN - 1) / NIN;
  endfunction

  task automatic model_reset();
    g_st = 0;
    for (int l = 0; l < NIN; l++) begin
      l_st[l] = 0; l_ptr[l] = 0; l_hold[l] = 0; l_img[l] = 0; l_dat[l] = 0;
    end
    for (int i = 0; i < NIMG; i++) m_cnt[i] = 0;
    sbq.delete();
    prev_lv = '0;
  endtask

  task automatic step(input logic st, input logic [NIMG-1:0] v, input logic st2);
    int gr[NIN];
    int gk[NIN];
    logic ldone[NIN];
    logic [NIMG-1:0] e_rdy, e_fv;
    logic [NIN-1:0][BW-1:0] e_fd;
    logic [NIN-1:0] lv;
    logic all_fin, run_entry;
    int nl, img, k, dimg;
    sb_t e;

    start = st;
    start2 = st2;
    src_valid = v;
    for (int i = 0; i < NIMG; i++)  src_data[i]  = BW'($urandom);
    for (int i = 0; i < NIMG2; i++) src_data2[i] = BW'($urandom);
    #1;

    e_rdy = '0; e_fv = '0; e_fd = '0; all_fin = 1'b1;
    for (int l = 0; l < NIN; l++) begin
      nl = nl_of(l);
      ldone[l] = 1'b1;
      for (int j = 0; j < nl; j++) if (m_cnt[l + j*NIN] < ISZ) ldone[l] = 1'b0;
      if (l_st[l] != 3) all_fin = 1'b0;
      gr[l] = -1; gk[l] = 0;
      if (l_st[l] == 1 && !ldone[l]) begin
        for (int j = 0; j < nl; j++) begin
          k = (l_ptr[l] + j) % nl;
          img = l + k*NIN;
          if (gr[l] < 0 && v[img] && m_cnt[img] < ISZ) begin gr[l] = img; gk[l] = k; end
        end
      end
      if (gr[l] >= 0) e_rdy[gr[l]] = 1'b1;
      if (l_st[l] == 2) begin
        e_fv[NIMG-1-l_img[l]] = 1'b1;
        e_fd[NIN-1-l] = BW'(l_dat[l]);
      end
    end

    check_val("src_ready", 32'(src_ready), 32'(e_rdy));
    check_val("fl_valid", 32'(fl_valid), 32'(e_fv));
    check_val("fl_data", 32'(fl_data), 32'(e_fd));
    check_val("busy", 32'(busy), 32'(g_st == 1));
    check_val("done", 32'(done), 32'(g_st == 2));
    for (int i = 0; i < NIMG; i++) gcount[i] += int'(src_ready[i]);
    if (done) done_cnt++;

    for (int l = 0; l < NIN; l++) begin
      lv[l] = 1'b0; dimg = -1;
      for (int j = 0; j < nl_of(l); j++) begin
        img = l + j*NIN;
        if (fl_valid[NIMG-1-img]) begin lv[l] = 1'b1; dimg = img; end
      end
      if (lv[l] && !prev_lv[l]) begin
        if (sbq.size() == 0) check_val("sb_pending", 32'(sbq.size()), 1);
        else begin
          e = sbq.pop_front();
          check_val("sb_lane", 32'(l), 32'(e.lane));
          check_val("sb_img", 32'(dimg), 32'(e.img));
          check_val("sb_data", 32'(fl_data[NIN-1-l]), 32'(e.data));
        end
      end
    end
    prev_lv = lv;

    run_entry = (g_st == 0) && st;
    for (int l = 0; l < NIN; l++) begin
      nl = nl_of(l);
      if (run_entry) begin
        l_st[l] = 1; l_ptr[l] = 0;
      end else begin
        case (l_st[l])
          1: begin
            if (ldone[l]) l_st[l] = 3;
            else if (gr[l] >= 0) begin
              m_cnt[gr[l]]++;
              l_ptr[l] = (gk[l] + 1) % nl;
              l_img[l] = gr[l];
              l_dat[l] = int'(src_data[gr[l]]);
              l_hold[l] = CPP;
              l_st[l] = 2;
              sbq.push_back('{lane: l, img: gr[l], data: int'(src_data[gr[l]])});
            end
          end
          2: begin
            l_hold[l]--;
            if (l_hold[l] == 0) l_st[l] = 1;
          end
          3: if (g_st == 0) l_st[l] = 0;
          default: ;
        endcase
      end
    end
    if (run_entry) for (int i = 0; i < NIMG; i++) m_cnt[i] = 0;
    case (g_st)
      0: if (st) g_st = 1;
      1: if (all_fin) g_st = 2;
      default: g_st = 0;
    endcase

    @(posedge clk); #1;
  endtask

  function automatic logic [NIMG-1:0] pat(input int mode, input int cyc);
    case (mode)
      1: return (cyc < 20) ? 4'b0001 : 4'b1111;
      2: return (cyc < 50) ? 4'b0011 : 4'b1111;
      3: return NIMG'($urandom_range(0, 15));
      default: return '1;
    endcase
  endfunction

  task automatic run_frame(input string name, input int mode, input int xstart, input int rst_at,
                           input logic with_d2);
    int cyc;
    cyc = 0;
    done_cnt = 0;
    for (int i = 0; i < NIMG; i++) gcount[i] = 0;
    do begin
      if (cyc == rst_at) begin
        check_val({name, " pre_rst_hold"}, 32'(fl_valid != '0), 1);
        start = 1'b0;
        src_valid = '0;
        res_n = 1'b0;
        #1;
        check_val({name, " rst_fl_valid"}, 32'(fl_valid), 0);
        check_val({name, " rst_fl_data"}, 32'(fl_data), 0);
        check_val({name, " rst_busy"}, 32'(busy), 0);
        check_val({name, " rst_src_ready"}, 32'(src_ready), 0);
        check_val({name, " rst_done"}, 32'(done), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        res_n = 1'b1;
        return;
      end
      step((cyc == 0) || (cyc == xstart), pat(mode, cyc), with_d2 && (cyc == 0));
      cyc++;
    end while (g_st != 0 && cyc < 3000);
    if (g_st != 0) check_val({name, " timeout_state"}, 32'(g_st), 0);
    for (int i = 0; i < NIMG; i++)
      check_val($sformatf("%s grants[%0d]", name, i), 32'(gcount[i]), ISZ);
    check_val({name, " done_pulses"}, 32'(done_cnt), 1);
    check_val({name, " sb_left"}, 32'(sbq.size()), 0);
  endtask

  // Monitor for the three-image instance.
  int c_cyc = 0;
  int s2_cyc = -1, d2_cyc = -1, d2_cnt = 0, l1_active = 0, l1_last = -1, l1_bad = 0;
  int g2[NIMG2] = '{default: 0};

  always @(posedge clk) c_cyc <= c_cyc + 1;

  always @(negedge clk) begin
    if (start2) s2_cyc <= c_cyc;
    if (done2) begin d2_cyc <= c_cyc; d2_cnt <= d2_cnt + 1; end
    for (int i = 0; i < NIMG2; i++) g2[i] <= g2[i] + int'(src_ready2[i]);
    if (fl_valid2[NIMG2-1-1]) begin l1_active <= l1_active + 1; l1_last <= c_cyc; end
    else if (fl_data2[NIN-1-1] != '0) l1_bad <= l1_bad + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    res_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset src_ready", 32'(src_ready), 0);
    check_val("reset fl_valid", 32'(fl_valid), 0);
    check_val("reset fl_data", 32'(fl_data), 0);
    check_val("reset busy", 32'(busy), 0);
    check_val("reset done", 32'(done), 0);
    res_n = 1'b1;

    run_frame("all_valid", 0, -1, -1, 1'b1);
    check_val("img3 done_latency", 32'(d2_cyc - s2_cyc), 93);
    check_val("img3 done_pulses", 32'(d2_cnt), 1);
    for (int i = 0; i < NIMG2; i++) check_val($sformatf("img3 grants[%0d]", i), 32'(g2[i]), ISZ);
    check_val("img3 lane1_hold_cycles", 32'(l1_active), 36);
    check_val("img3 lane1_last_hold", 32'(l1_last - s2_cyc), 45);
    check_val("img3 lane1_data_idle", 32'(l1_bad), 0);

    run_frame("img0_first", 1, -1, -1, 1'b0);
    run_frame("img1_full", 2, -1, -1, 1'b0);
    run_frame("restart_ignored", 0, 30, -1, 1'b0);
    run_frame("reset_hold", 0, -1, 3, 1'b0);
    run_frame("after_reset", 0, -1, -1, 1'b0);
    run_frame("random_valid", 3, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
